// File: rtl/if_fetch_stage_pkg.sv
// rtl/if_fetch_stage_pkg.sv - shared types and constants for the instruction-fetch stage
//
// Contents:
//   word_t         32-bit address / instruction word
//   fetch_state_t  fetch sequencer states {ST_FETCH, ST_HOLD, ST_DROP}
//   NOP_INSTR      default instruction word presented while IF/ID is empty
//   PC_INC         fetch address increment
//   PC_ALIGN_MASK  forces the two low address bits to zero
package if_fetch_stage_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_t;

    localparam word_t NOP_INSTR     = 32'h0000_0000;
    localparam word_t PC_INC        = 32'd4;
    localparam word_t PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/if_fetch_stage_hold_buf.sv
// rtl/if_fetch_stage_hold_buf.sv - one-entry {pc, instr} parking register for stalled fetches
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   load           capture load_pc/load_instr and mark the entry valid
//   clear          drop the entry (ignored when load is also asserted)
//   load_pc        PC of the instruction being parked
//   load_instr     instruction word being parked
//   valid          entry holds a parked instruction
//   pc, instr      parked contents
module if_hold_buf
    import if_fetch_stage_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  clear,
    input  word_t load_pc,
    input  word_t load_instr,
    output logic  valid,
    output word_t pc,
    output word_t instr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction-fetch stage: fetch PC, imem req/ack, IF/ID register
//
// Parameters:
//   RESET_PC        fetch address after reset
//   NOP_INSTR       value driven on ifid_instr while ifid_valid=0
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   stall           ID cannot accept; IF/ID contents are held
//   redirect_valid  branch/jump taken: flush and refetch from redirect_pc
//   redirect_pc     redirect target (bits [1:0] ignored)
//   imem_req        fetch request; imem_addr stable until acked
//   imem_addr       fetch address
//   imem_ack        memory returns imem_rdata this cycle
//   imem_rdata      instruction word
//   ifid_valid      IF/ID holds a live instruction
//   ifid_pc         PC of the instruction in IF/ID
//   ifid_pc4        ifid_pc + 4 (wrapping)
//   ifid_instr      instruction word, NOP_INSTR when invalid
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = if_fetch_stage_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr
);

    import if_fetch_stage_pkg::*;

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        drop_addr_q, drop_addr_d;
    logic         ifid_valid_q, ifid_valid_d;
    word_t        ifid_pc_q, ifid_pc_d;
    word_t        ifid_pc4_q, ifid_pc4_d;
    word_t        ifid_instr_q, ifid_instr_d;

    logic         hb_load, hb_clear, hb_valid;
    word_t        hb_pc, hb_instr;

    logic         xfer;
    logic         accept;
    word_t        redirect_target;
    word_t        pc_next_seq;

    if_hold_buf u_hold_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (hb_load),
        .clear      (hb_clear),
        .load_pc    (pc_q),
        .load_instr (imem_rdata),
        .valid      (hb_valid),
        .pc         (hb_pc),
        .instr      (hb_instr)
    );

    // Request is gated by rst_n so it drops the moment reset is applied,
    // abandoning whatever transfer was outstanding.
    assign imem_req  = rst_n && (state_q != ST_HOLD);
    // In DROP the stale address must stay on the bus until its response
    // arrives, even though pc already points at the redirect target.
    assign imem_addr = (state_q == ST_DROP) ? drop_addr_q : pc_q;

    assign xfer            = imem_req && imem_ack;
    assign accept          = !stall || !ifid_valid_q;
    assign redirect_target = redirect_pc & PC_ALIGN_MASK;
    assign pc_next_seq     = pc_q + PC_INC;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_addr_d  = drop_addr_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        hb_load      = 1'b0;
        hb_clear     = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                if (redirect_valid) begin
                    // Flush wins over stall; any same-cycle rdata is wrong-path.
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                    pc_d         = redirect_target;
                    if (!xfer) begin
                        drop_addr_d = pc_q;
                        state_d     = ST_DROP;
                    end
                end else if (xfer) begin
                    pc_d = pc_next_seq;
                    if (accept) begin
                        ifid_valid_d = 1'b1;
                        ifid_pc_d    = pc_q;
                        ifid_pc4_d   = pc_next_seq;
                        ifid_instr_d = imem_rdata;
                    end else begin
                        hb_load = 1'b1;
                        state_d = ST_HOLD;
                    end
                end else if (!stall) begin
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                end
            end

            ST_HOLD: begin
                if (redirect_valid) begin
                    hb_clear     = 1'b1;
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                    pc_d         = redirect_target;
                    state_d      = ST_FETCH;
                end else if (!stall && hb_valid) begin
                    hb_clear     = 1'b1;
                    ifid_valid_d = 1'b1;
                    ifid_pc_d    = hb_pc;
                    ifid_pc4_d   = hb_pc + PC_INC;
                    ifid_instr_d = hb_instr;
                    state_d      = ST_FETCH;
                end
            end

            ST_DROP: begin
                if (redirect_valid) begin
                    // Latest redirect wins; the stale request itself is untouched.
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                    pc_d         = redirect_target;
                end
                if (xfer) begin
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC & PC_ALIGN_MASK;
            drop_addr_q  <= '0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
            ifid_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_addr_q  <= drop_addr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
        end
    end

    assign ifid_valid = ifid_valid_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign ifid_instr = ifid_valid_q ? ifid_instr_q : NOP_INSTR;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TB_NOP      = 32'h0000_0000;
    localparam logic [31:0] TB_XOR      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_pc;

    if_fetch_stage #(
        .RESET_PC  (TB_RESET_PC),
        .NOP_INSTR (TB_NOP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .ifid_valid     (ifid_valid),
        .ifid_pc        (ifid_pc),
        .ifid_pc4       (ifid_pc4),
        .ifid_instr     (ifid_instr)
    );

    always #5 clk = ~clk;

    // Memory content is a fixed function of the address.
    assign imem_rdata = imem_addr ^ TB_XOR;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sb_push(input logic [31:0] pc);
        sb_entry_t e;
        e.pc    = pc;
        e.instr = pc ^ TB_XOR;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input string tag);
        sb_entry_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_valid"}, {31'd0, ifid_valid}, 32'd1);
            chk({tag, "_pc"},    ifid_pc,    e.pc);
            chk({tag, "_pc4"},   ifid_pc4,   e.pc + 32'd4);
            chk({tag, "_instr"}, ifid_instr, e.instr);
        end
    endtask

    // Zero-wait acks with no stall: one instruction per cycle.
    task automatic run_stream(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            stall    = 1'b0;
            imem_ack = 1'b1;
            chk({tag, "_req"},  {31'd0, imem_req}, 32'd1);
            chk({tag, "_addr"}, imem_addr, exp_pc);
            sb_push(exp_pc);
            exp_pc = exp_pc + 32'd4;
            tick();
            sb_pop_check(tag);
        end
        imem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_ack       = 1'b0;
        exp_pc         = TB_RESET_PC;

        // Reset state
        tick();
        tick();
        chk("rst_req",   {31'd0, imem_req},   32'd0);
        chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("rst_pc",    ifid_pc,    32'd0);
        chk("rst_pc4",   ifid_pc4,   32'd0);
        chk("rst_instr", ifid_instr, TB_NOP);
        rst_n = 1'b1;
        #1;
        chk("rst_first_addr", imem_addr, TB_RESET_PC);

        // Back-to-back stream 0,4,8,...
        run_stream(8, "stream");

        // Redirect with same-cycle ack: data dropped, fetch from 0x10
        imem_ack       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        tick();
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        chk("redir_ack_valid", {31'd0, ifid_valid}, 32'd0);
        chk("redir_ack_instr", ifid_instr, TB_NOP);

        // Ack three cycles late at 0x10
        exp_pc = 32'h10;
        for (int k = 0; k < 3; k++) begin
            chk("wait_addr",  imem_addr, 32'h10);
            chk("wait_req",   {31'd0, imem_req},   32'd1);
            chk("wait_valid", {31'd0, ifid_valid}, 32'd0);
            tick();
        end
        run_stream(1, "late");

        // Reach 0x20 with a valid IF/ID, then stall + ack -> HOLD
        run_stream(3, "pre_hold");
        stall    = 1'b1;
        imem_ack = 1'b1;
        chk("hold_ack_addr", imem_addr, 32'h20);
        sb_push(32'h20);
        tick();
        imem_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("hold_req",   {31'd0, imem_req},   32'd0);
            chk("hold_valid", {31'd0, ifid_valid}, 32'd1);
            chk("hold_pc",    ifid_pc, 32'h1C);
            tick();
        end
        stall = 1'b0;
        tick();
        sb_pop_check("hold_release");
        chk("hold_next_addr", imem_addr, 32'h24);
        exp_pc = 32'h24;

        // Redirect to 0x103 while 0x40 is unacked -> DROP
        run_stream(7, "pre_drop");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("drop_addr",  imem_addr, 32'h40);
            chk("drop_req",   {31'd0, imem_req},   32'd1);
            chk("drop_valid", {31'd0, ifid_valid}, 32'd0);
            tick();
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("drop_done_valid", {31'd0, ifid_valid}, 32'd0);
        exp_pc = 32'h100;
        run_stream(2, "post_drop");

        // Redirect while in HOLD with stall=1
        stall    = 1'b1;
        imem_ack = 1'b1;
        chk("hold2_addr", imem_addr, 32'h108);
        tick();
        imem_ack = 1'b0;
        chk("hold2_req", {31'd0, imem_req}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        chk("hold2_flush_valid", {31'd0, ifid_valid}, 32'd0);
        chk("hold2_flush_instr", ifid_instr, TB_NOP);
        chk("hold2_target_req",  {31'd0, imem_req}, 32'd1);
        chk("hold2_target_addr", imem_addr, 32'hFFFF_FFF8);
        stall  = 1'b0;
        exp_pc = 32'hFFFF_FFF8;
        run_stream(3, "wrap");
        chk("wrap_next_addr", imem_addr, 32'h4);

        // Reset mid-wait at 0x80
        imem_ack       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        tick();
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        tick();
        chk("mid_wait_addr", imem_addr, 32'h80);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req",   {31'd0, imem_req},   32'd0);
        chk("mid_rst_valid", {31'd0, ifid_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_req",   {31'd0, imem_req},   32'd1);
        chk("post_rst_addr",  imem_addr, TB_RESET_PC);
        chk("post_rst_valid", {31'd0, ifid_valid}, 32'd0);
        @(negedge clk);
        exp_pc = TB_RESET_PC;
        run_stream(2, "post_rst");

        chk("sb_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage that sits between the PC register and the ID stage. It owns the fetch PC, issues requests to instruction memory over a req/ack handshake, and loads the IF/ID pipeline register. It honours ID-stage stalls through a one-entry hold buffer and handles branch/jump redirects, including discarding stale in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
NOP_INSTR, 32'h0000_0000, value driven on ifid_instr when ifid_valid=0

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
stall  in  1  ID stage cannot accept; hold IF/ID contents
redirect_valid  in  1  branch/jump taken; flush and refetch
redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 00)
imem_req  out  1  fetch request
imem_addr  out  32  fetch address; stable while imem_req=1 until ack
imem_ack  in  1  memory returns data this cycle; valid only while imem_req=1
imem_rdata  in  32  instruction word, valid with imem_ack
ifid_valid  out  1  IF/ID holds a live instruction
ifid_pc  out  32  PC of the instruction in IF/ID
ifid_pc4  out  32  ifid_pc + 4, mod 2^32
ifid_instr  out  32  instruction word; NOP_INSTR when invalid

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=FETCH, hold buffer empty, ifid_valid=0, ifid_pc=0, ifid_pc4=0, ifid_instr=NOP_INSTR. imem_req=0 while rst_n=0.
- Any ack pending at reset is abandoned. After reset, memory must not ack until a new request is issued.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
  - HOLD: imem_req=0; the instruction is parked in the hold buffer.
  - DROP: imem_req=1, imem_addr=stale address; waits to discard one response.
- Transfer: completes on a posedge with imem_req=1 and imem_ack=1. Zero-wait ack is legal and sustains one instruction per cycle.
- "Accept" means stall=0 or ifid_valid=0.
- FETCH, ack, accept, no redirect: IF/ID <= {1, pc, pc+4, rdata}; pc <= pc+4; stay FETCH.
- FETCH, ack, not accept: hold buffer <= {pc, rdata}; pc <= pc+4; go to HOLD. IF/ID is unchanged.
- FETCH, no ack: if stall=0, ifid_valid <= 0 (bubble, instr=NOP_INSTR); otherwise IF/ID is unchanged.
- HOLD, stall=0: IF/ID <= hold buffer (valid=1); go to FETCH.
- Redirect has the highest priority in every state. It also wins over stall: ifid_valid <= 0 at the next edge regardless of stall.
  - FETCH with ack the same cycle: drop rdata; pc <= redirect_pc; stay FETCH.
  - FETCH without ack: pc <= redirect_pc; go to DROP. imem_addr keeps the old address until ack.
  - HOLD: discard the hold buffer; pc <= redirect_pc; go to FETCH.
  - DROP: pc <= new redirect_pc (latest wins); stay DROP.
- DROP, ack: discard rdata; go to FETCH with the redirected pc. imem_addr in DROP is the saved stale address, not pc.
- PC arithmetic: 32-bit unsigned, wraps (32'hFFFF_FFFC + 4 = 0); bits [1:0] always 00.
- Invariants:
  - ifid_instr=NOP_INSTR whenever ifid_valid=0.
  - imem_addr/imem_req never change while a request is unacked, except on reset.

Decomposition:
- Shared package: fetch state enum {FETCH, HOLD, DROP}; NOP_INSTR; PC_INC=4.
- One natural sub-module: if_hold_buf, a one-entry {pc, instr} register with load/clear/valid.

Test Plan:
- Reset, ack tied 1, rdata=addr^32'hA5A5_0000 → imem_addr 0,4,8,…; ifid_pc 0,4,8 on consecutive cycles, instr matches.
- Ack 3 cycles after req at pc=0x10, stall=0 → imem_addr held at 0x10 for 3 cycles, ifid_valid=0 until ack edge, then ifid_pc=0x10, ifid_pc4=0x14.
- ifid_valid=1, stall=1, ack arrives for pc=0x20 → HOLD, imem_req=0, IF/ID unchanged. Stall drops → ifid_pc=0x20, next req addr 0x24.
- Redirect to 0x103 with no ack pending at addr 0x40 → addr stays 0x40 until ack, response discarded, next req addr 0x100, ifid_valid=0 throughout.
- Redirect with stall=1 and in HOLD → ifid_valid=0 next cycle, hold buffer dropped, next req addr = target. Also check pc=0xFFFF_FFFC fetch followed by 0x0.
- Assert rst_n=0 mid-wait at addr 0x80 → imem_req=0 immediately. After release, first req addr = RESET_PC, ifid_valid=0.
